// File: rtl/turn_control_unit_pkg.sv
// Shared types and helpers for the turn control unit: FSM state encoding
// and the width of the per-turn seconds counter.
package turn_ctrl_pkg;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_RUNNING     = 2'd1;
    localparam logic [1:0] ST_WIN_HOLD    = 2'd2;
    localparam logic [1:0] ST_RESET_PULSE = 2'd3;

    // Encodings are pinned so older tooling that probes raw state bits still matches.
    typedef enum logic [1:0] {
        IDLE        = ST_IDLE,
        RUNNING     = ST_RUNNING,
        WIN_HOLD    = ST_WIN_HOLD,
        RESET_PULSE = ST_RESET_PULSE
    } turn_state_t;

    function automatic int seconds_width(input int turn_seconds);
        return $clog2(turn_seconds + 1);
    endfunction

endpackage

// File: rtl/turn_control_unit_if.sv
// Button/turn bus between the game-side logic (master) and the turn control unit (slave).
interface turn_control_unit_if
    import turn_ctrl_pkg::*;
#(
    parameter int NUM_BTNS     = 4,
    parameter int TURN_SECONDS = 10,
    parameter int CNT_W        = 4
);

    localparam int SEC_W = seconds_width(TURN_SECONDS);

    logic [NUM_BTNS-1:0] btn_n;
    logic                turn_active;
    logic                win_flag;
    logic [NUM_BTNS-1:0] btn_pulse;
    logic                move_made;
    logic                timeout_pulse;
    logic                game_reset;
    logic [SEC_W-1:0]    seconds;
    logic [CNT_W-1:0]    move_count;

    modport master (
        output btn_n, turn_active, win_flag,
        input  btn_pulse, move_made, timeout_pulse, game_reset, seconds, move_count
    );

    modport slave (
        input  btn_n, turn_active, win_flag,
        output btn_pulse, move_made, timeout_pulse, game_reset, seconds, move_count
    );

endinterface

// File: rtl/turn_control_unit_second_ticker.sv
// Prescaler producing a one-cycle tick every CLK_HZ cycles; clear restarts the count.
module second_ticker #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q;

    assign tick = (presc_q == LAST) & ~clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (clear || presc_q == LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule

// File: rtl/turn_control_unit.sv
// Turns debounced buttons into press pulses, times turns, handles win hold-off and game reset.
// Optional: define TURN_TIMEOUT_EN to commit an automatic move when a turn runs out.
module turn_control_unit
    import turn_ctrl_pkg::*;
#(
    parameter int NUM_BTNS         = 4,
    parameter int ACCEPT_IDX       = 2,
    parameter int RESET_IDX        = 3,
    parameter int CLK_HZ           = 25_000_000,
    parameter int TURN_SECONDS     = 10,
    parameter int WIN_DELAY_CYCLES = 12_500_000,
    parameter int CNT_W            = 4
) (
    input logic                clk,
    input logic                reset,
    turn_control_unit_if.slave bus
);

    localparam int               SEC_W    = seconds_width(TURN_SECONDS);
    localparam int               DLY_W    = $clog2(WIN_DELAY_CYCLES + 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(TURN_SECONDS);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(WIN_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    turn_state_t         state_q;
    turn_state_t         state_d;
    logic [NUM_BTNS-1:0] btn_prev_q;
    logic [NUM_BTNS-1:0] pulse_q;
    logic [NUM_BTNS-1:0] press_edge;
    logic                win_prev_q;
    logic                win_rise;
    logic [DLY_W-1:0]    delay_q;
    logic [SEC_W-1:0]    seconds_q;
    logic [CNT_W-1:0]    move_count_q;
    logic                move_made_q;
    logic                timeout_q;
    logic                game_reset_q;
    logic                reset_req;
    logic                accept_now;
    logic                timeout_now;
    logic                move_now;
    logic                sec_tick;
    logic                ticker_clear;

    assign press_edge = btn_prev_q & ~bus.btn_n;
    assign win_rise   = bus.win_flag & ~win_prev_q;
    assign reset_req  = press_edge[RESET_IDX];
    assign accept_now = (state_q == RUNNING) & press_edge[ACCEPT_IDX];

`ifdef TURN_TIMEOUT_EN
    // The ~move_made_q term stops a second timeout while seconds still shows the limit.
    assign timeout_now = (state_q == RUNNING) & (seconds_q == SEC_MAX) & ~move_made_q;
`else
    assign timeout_now = 1'b0;
`endif

    assign move_now     = (accept_now | timeout_now) & ~reset_req & ~win_rise;
    assign ticker_clear = (state_d != RUNNING) | move_made_q;

    second_ticker #(
        .CLK_HZ(CLK_HZ)
    ) u_ticker (
        .clk  (clk),
        .reset(reset),
        .clear(ticker_clear),
        .tick (sec_tick)
    );

    // A reset press beats a simultaneous win edge; a win edge restarts the hold-off.
    always_comb begin
        state_d = state_q;
        if (reset_req) begin
            state_d = RESET_PULSE;
        end else if (win_rise && state_q != RESET_PULSE) begin
            state_d = WIN_HOLD;
        end else begin
            case (state_q)
                IDLE:        if (bus.turn_active) state_d = RUNNING;
                RUNNING:     if (!bus.turn_active) state_d = IDLE;
                WIN_HOLD:    if (delay_q == DLY_LAST) state_d = RESET_PULSE;
                RESET_PULSE: state_d = IDLE;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            btn_prev_q   <= '0;
            pulse_q      <= '0;
            win_prev_q   <= 1'b0;
            delay_q      <= '0;
            seconds_q    <= '0;
            move_count_q <= '0;
            move_made_q  <= 1'b0;
            timeout_q    <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= bus.btn_n;
            pulse_q      <= press_edge;
            win_prev_q   <= bus.win_flag;
            move_made_q  <= move_now;
            timeout_q    <= timeout_now & ~reset_req & ~win_rise;
            game_reset_q <= (state_q == RESET_PULSE);

            if (state_q == WIN_HOLD && !win_rise) begin
                delay_q <= delay_q + 1'b1;
            end else begin
                delay_q <= '0;
            end

            if (ticker_clear) begin
                seconds_q <= '0;
            end else if (sec_tick && seconds_q != SEC_MAX) begin
                seconds_q <= seconds_q + 1'b1;
            end

            if (game_reset_q) begin
                move_count_q <= '0;
            end else if (move_made_q && move_count_q != CNT_MAX) begin
                move_count_q <= move_count_q + 1'b1;
            end
        end
    end

    assign bus.btn_pulse     = (state_q == WIN_HOLD) ? '0 : pulse_q;
    assign bus.move_made     = move_made_q;
    assign bus.timeout_pulse = timeout_q;
    assign bus.game_reset    = game_reset_q;
    assign bus.seconds       = seconds_q;
    assign bus.move_count    = move_count_q;

endmodule

// File: tb/tb_turn_control_unit.sv
// Bench for turn_control_unit: directed scenarios plus random buttons/win/turn activity,
// every cycle compared against a behavioural model of the turn rules.
module tb_turn_control_unit;

    localparam int NUM_BTNS         = 4;
    localparam int ACCEPT_IDX       = 2;
    localparam int RESET_IDX        = 3;
    localparam int CLK_HZ           = 4;
    localparam int TURN_SECONDS     = 3;
    localparam int WIN_DELAY_CYCLES = 5;
    localparam int CNT_W            = 4;
    localparam int CNT_SAT          = 2**CNT_W - 1;
`ifdef TURN_TIMEOUT_EN
    localparam int TIMEOUT_EN = 1;
`else
    localparam int TIMEOUT_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    turn_control_unit_if #(
        .NUM_BTNS    (NUM_BTNS),
        .TURN_SECONDS(TURN_SECONDS),
        .CNT_W       (CNT_W)
    ) bus ();

    turn_control_unit #(
        .NUM_BTNS        (NUM_BTNS),
        .ACCEPT_IDX      (ACCEPT_IDX),
        .RESET_IDX       (RESET_IDX),
        .CLK_HZ          (CLK_HZ),
        .TURN_SECONDS    (TURN_SECONDS),
        .WIN_DELAY_CYCLES(WIN_DELAY_CYCLES),
        .CNT_W           (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: what the turn supervisor is doing, and what it will show next cycle.
    logic [NUM_BTNS-1:0] m_prev;
    logic                m_win_prev;
    logic                m_playing;
    logic                m_holding;
    logic                m_reset_due;
    int                  m_hold_left;
    int                  m_presc;
    int                  m_sec;
    int                  m_count;
    logic [NUM_BTNS-1:0] e_pulse;
    logic                e_move;
    logic                e_timeout;
    logic                e_reset;

    task automatic applyStimulus(input logic [NUM_BTNS-1:0] btn, input logic active, input logic win);
        bus.btn_n       = btn;
        bus.turn_active = active;
        bus.win_flag    = win;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_edge();
        logic [NUM_BTNS-1:0] press;
        logic rise, rst_req, go_hold, accept, tmo, move;
        logic nxt_play, nxt_hold, nxt_due;
        if (!reset) begin
            m_prev = '0; m_win_prev = 1'b0; m_playing = 1'b0; m_holding = 1'b0;
            m_reset_due = 1'b0; m_hold_left = 0; m_presc = 0; m_sec = 0; m_count = 0;
            e_pulse = '0; e_move = 1'b0; e_timeout = 1'b0; e_reset = 1'b0;
            return;
        end
        press   = m_prev & ~bus.btn_n;
        rise    = bus.win_flag & ~m_win_prev;
        rst_req = press[RESET_IDX];
        go_hold = !rst_req && rise && !m_reset_due;
        accept  = m_playing && press[ACCEPT_IDX];
        tmo     = (TIMEOUT_EN != 0) && m_playing && (m_sec == TURN_SECONDS) && !e_move;
        move    = (accept || tmo) && !rst_req && !go_hold;

        nxt_play = m_playing;
        nxt_hold = m_holding;
        nxt_due  = 1'b0;
        if (rst_req) begin
            nxt_due = 1'b1; nxt_play = 1'b0; nxt_hold = 1'b0;
        end else if (go_hold) begin
            nxt_hold = 1'b1; nxt_play = 1'b0; m_hold_left = WIN_DELAY_CYCLES;
        end else if (m_reset_due) begin
            nxt_play = 1'b0;
        end else if (m_holding) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                nxt_hold = 1'b0; nxt_due = 1'b1;
            end
        end else begin
            nxt_play = bus.turn_active;
        end

        if (!nxt_play || e_move) begin
            m_presc = 0; m_sec = 0;
        end else if (m_presc == CLK_HZ - 1) begin
            m_presc = 0;
            if (m_sec < TURN_SECONDS) m_sec++;
        end else begin
            m_presc++;
        end

        if (e_reset) m_count = 0;
        else if (e_move && m_count < CNT_SAT) m_count++;

        e_reset     = m_reset_due;
        e_move      = move;
        e_timeout   = tmo && !rst_req && !go_hold;
        e_pulse     = nxt_hold ? '0 : press;
        m_prev      = bus.btn_n;
        m_win_prev  = bus.win_flag;
        m_playing   = nxt_play;
        m_holding   = nxt_hold;
        m_reset_due = nxt_due;
    endtask

    task automatic compare_model();
        checkOutput("btn_pulse",     bus.btn_pulse,     e_pulse);
        checkOutput("move_made",     bus.move_made,     e_move);
        checkOutput("timeout_pulse", bus.timeout_pulse, e_timeout);
        checkOutput("game_reset",    bus.game_reset,    e_reset);
        checkOutput("seconds",       bus.seconds,       m_sec);
        checkOutput("move_count",    bus.move_count,    m_count);
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    initial begin
        int moves, timeouts, max_sec, pulses, waited, base_count, resets, hold_moves, hold_pulses, reset_at;
        int first_sec[4];

        $display("[TB] start, timeout feature %0d", TIMEOUT_EN);
        reset = 1'b0;
        applyStimulus(4'b1110, 1'b0, 1'b0);
        repeat (3) run_cycle();
        checkOutput("rst_btn_pulse",  bus.btn_pulse,  0);
        checkOutput("rst_move_made",  bus.move_made,  0);
        checkOutput("rst_game_reset", bus.game_reset, 0);
        checkOutput("rst_seconds",    bus.seconds,    0);
        checkOutput("rst_move_count", bus.move_count, 0);

        // Button 0 held low across reset release must not pulse until re-pressed.
        reset = 1'b1;
        pulses = 0;
        repeat (4) begin run_cycle(); if (bus.btn_pulse[0]) pulses++; end
        checkOutput("held_btn_no_pulse", pulses, 0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        repeat (2) run_cycle();
        applyStimulus(4'b1110, 1'b0, 1'b0);
        pulses = 0;
        repeat (4) begin run_cycle(); if (bus.btn_pulse[0]) pulses++; end
        checkOutput("repress_one_pulse", pulses, 1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        run_cycle();

        // Untouched turn: seconds step every CLK_HZ cycles up to the limit.
        applyStimulus(4'b1111, 1'b1, 1'b0);
        moves = 0; timeouts = 0; max_sec = 0;
        for (int i = 0; i < 4; i++) first_sec[i] = -1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            run_cycle();
            if (bus.move_made) moves++;
            if (bus.timeout_pulse) timeouts++;
            if (int'(bus.seconds) > max_sec) max_sec = int'(bus.seconds);
            if (first_sec[bus.seconds] == -1) first_sec[bus.seconds] = cyc;
        end
        checkOutput("timeout_moves", moves, TIMEOUT_EN);
        checkOutput("timeout_pulses", timeouts, TIMEOUT_EN);
        checkOutput("seconds_peak", max_sec, TURN_SECONDS);
        checkOutput("sec_spacing_12", first_sec[2] - first_sec[1], CLK_HZ);
        checkOutput("sec_spacing_23", first_sec[3] - first_sec[2], CLK_HZ);
        run_cycle();
        checkOutput("count_after_timeout", bus.move_count, TIMEOUT_EN);

        // Accept press while seconds reads 2.
        applyStimulus(4'b1111, 1'b0, 1'b0);
        run_cycle();
        applyStimulus(4'b1111, 1'b1, 1'b0);
        waited = 0;
        while (bus.seconds != 2 && waited < 20) begin run_cycle(); waited++; end
        checkOutput("wait_sec2", bus.seconds, 2);
        applyStimulus(4'b1011, 1'b1, 1'b0);
        run_cycle();
        checkOutput("accept_move", bus.move_made, 1);
        checkOutput("accept_no_timeout", bus.timeout_pulse, 0);
        checkOutput("accept_pulse", bus.btn_pulse[ACCEPT_IDX], 1);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        run_cycle();
        checkOutput("accept_sec_clear", bus.seconds, 0);
        repeat (3) run_cycle();
        checkOutput("presc_restart_hold", bus.seconds, 0);
        run_cycle();
        checkOutput("presc_restart_tick", bus.seconds, 1);

        // Accept press landing in the timeout cycle.
        waited = 0;
        while (bus.seconds != TURN_SECONDS && waited < 20) begin run_cycle(); waited++; end
        checkOutput("wait_sec_limit", bus.seconds, TURN_SECONDS);
        base_count = int'(bus.move_count);
        applyStimulus(4'b1011, 1'b1, 1'b0);
        moves = 0; timeouts = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            if (k == 0) applyStimulus(4'b1111, 1'b1, 1'b0);
            if (bus.move_made) moves++;
            if (bus.timeout_pulse) timeouts++;
        end
        checkOutput("collide_moves", moves, 1);
        checkOutput("collide_timeouts", timeouts, TIMEOUT_EN);
        checkOutput("collide_count", bus.move_count, base_count + 1);

        // Win: accept presses ignored, game_reset WIN_DELAY_CYCLES+2 cycles later.
        applyStimulus(4'b1111, 1'b1, 1'b1);
        resets = 0; hold_moves = 0; hold_pulses = 0; reset_at = -1;
        for (int k = 1; k <= 10; k++) begin
            run_cycle();
            if (k == 2) applyStimulus(4'b1011, 1'b1, 1'b1);
            if (k == 4) applyStimulus(4'b1111, 1'b1, 1'b1);
            if (bus.game_reset) begin resets++; if (reset_at < 0) reset_at = k; end
            if (k < WIN_DELAY_CYCLES + 2 && bus.move_made) hold_moves++;
            if (k < WIN_DELAY_CYCLES + 2 && bus.btn_pulse != '0) hold_pulses++;
        end
        checkOutput("win_reset_delay", reset_at, WIN_DELAY_CYCLES + 2);
        checkOutput("win_reset_width", resets, 1);
        checkOutput("win_no_moves", hold_moves, 0);
        checkOutput("win_no_pulses", hold_pulses, 0);
        checkOutput("win_count_clear", bus.move_count, 0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        run_cycle();

        // Saturating move counter, then a reset-button game reset.
        repeat (2**CNT_W + 2) begin
            applyStimulus(4'b1011, 1'b1, 1'b0);
            run_cycle();
            applyStimulus(4'b1111, 1'b1, 1'b0);
            run_cycle();
        end
        run_cycle();
        checkOutput("count_saturated", bus.move_count, CNT_SAT);
        applyStimulus(4'b0111, 1'b1, 1'b0);
        run_cycle();
        checkOutput("rstbtn_pulse", bus.btn_pulse[RESET_IDX], 1);
        run_cycle();
        checkOutput("rstbtn_game_reset", bus.game_reset, 1);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        run_cycle();
        checkOutput("rstbtn_count_clear", bus.move_count, 0);
        checkOutput("rstbtn_reset_single", bus.game_reset, 0);

        // Random activity against the model.
        for (int i = 0; i < 600; i++) begin
            logic [NUM_BTNS-1:0] b;
            logic act, win;
            b   = bus.btn_n;
            act = bus.turn_active;
            win = bus.win_flag;
            for (int j = 0; j < NUM_BTNS; j++) begin
                if (j == RESET_IDX) begin
                    if ($urandom_range(0, 39) == 0) b[j] = ~b[j];
                end else if ($urandom_range(0, 5) == 0) begin
                    b[j] = ~b[j];
                end
            end
            if ($urandom_range(0, 24) == 0) act = ~act;
            if ($urandom_range(0, 29) == 0) win = ~win;
            applyStimulus(b, act, win);
            reset = (i >= 300 && i < 302) ? 1'b0 : 1'b1;
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/turn_control_unit.md
# turn_control_unit

Parametrised player-input and turn-supervision block between the debounced push-buttons and the game FSM. Converts N active-low buttons into one-cycle press pulses and times each turn in whole seconds. Issues an automatic move on turn timeout, holds off after a win before pulsing a game reset, and counts moves. Single clock domain (pixel clock).

## Interface
- NUM_BTNS, 4: number of button inputs (≥2)
- ACCEPT_IDX, 2: button index that commits a move
- RESET_IDX, 3: button index that requests a game reset
- CLK_HZ, 25_000_000: clock cycles per second tick
- TURN_SECONDS, 10: turn timeout in seconds (≥1)
- WIN_DELAY_CYCLES, 12_500_000: hold-off between win detection and game reset (≥1)
- CNT_W, 4: move counter width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- btn_n  in  NUM_BTNS  debounced buttons, 0 = pressed
- turn_active  in  1  game FSM is in its play state
- win_flag  in  1  game FSM reports a win (level)
- btn_pulse  out  NUM_BTNS  one-cycle press pulse per button
- move_made  out  1  one-cycle commit pulse (button or timeout)
- timeout_pulse  out  1  one-cycle, marks an automatic move
- game_reset  out  1  one-cycle active-high reset to game FSM/VGA
- seconds  out  $clog2(TURN_SECONDS+1)  elapsed seconds in current turn
- move_count  out  CNT_W  moves since last game reset, saturating

## Operation
- Edge detect: btn_prev registered from btn_n; btn_pulse[i] = registered (btn_prev[i] & ~btn_n[i]). btn_prev resets to all-zero (pressed), so a button held through reset produces no pulse until released and pressed again.
- States: IDLE, RUNNING, WIN_HOLD, RESET_PULSE.
- IDLE: seconds = 0, prescaler = 0. turn_active=1 → RUNNING.
- RUNNING: prescaler counts 0..CLK_HZ-1; wrap increments seconds. Accept press → move_made, seconds and prescaler cleared, stay. seconds == TURN_SECONDS → move_made + timeout_pulse, seconds and prescaler cleared. Accept press in same cycle as timeout → exactly one move_made; timeout_pulse asserted. turn_active=0 → IDLE.
- Rising edge of win_flag (any state except RESET_PULSE) → WIN_HOLD, delay counter cleared. WIN_HOLD: counts WIN_DELAY_CYCLES; move_made, timeout and btn_pulse all forced 0; on terminal count → RESET_PULSE.
- RESET_PULSE: game_reset = 1 for one cycle → IDLE. Also entered from any state on RESET_IDX press; reset press wins over win edge in the same cycle.
- move_count: +1 per move_made, saturates at 2^CNT_W-1, cleared when game_reset asserts.

## Timing
- Reset: all outputs 0; state IDLE; counters 0; win_flag_prev 0.
- btn_pulse: cycle N+1 after btn_n first seen low in cycle N.
- move_made from accept press: same cycle as btn_pulse[ACCEPT_IDX].
- Timeout: move_made/timeout_pulse in the cycle after seconds first reads TURN_SECONDS; seconds reads 0 in the following cycle.
- game_reset from win: WIN_DELAY_CYCLES+2 cycles after win_flag rises. From reset button: cycle after btn_pulse[RESET_IDX].
- move_count updates the cycle after move_made.

## Configuration
- TURN_TIMEOUT_EN defined: automatic move on timeout as above.
- Not defined: seconds still counts but saturates at TURN_SECONDS; no automatic move_made; timeout_pulse tied 0.

## Structure
- Package turn_ctrl_pkg: state enum turn_state_t, helper function for seconds width.
- Sub-module second_ticker: prescaler with clear input, emits one-cycle tick every CLK_HZ cycles.

## Test plan
- CLK_HZ=4, TURN_SECONDS=3, turn_active=1, no presses -> seconds 0,1,2,3 at 4-cycle spacing; move_made+timeout_pulse once; seconds back to 0; move_count=1.
- Accept press at seconds=2 -> single move_made, timeout_pulse 0, seconds=0, prescaler restarts.
- Accept press in timeout cycle -> exactly one move_made, timeout_pulse 1, move_count +1.
- WIN_DELAY_CYCLES=5, win_flag rises -> accept presses ignored; game_reset high exactly 7 cycles later for 1 cycle; move_count=0.
- Button held low through reset deassert -> no btn_pulse; release then press -> one pulse.
- 2^CNT_W+2 accept presses -> move_count saturates at 15 (CNT_W=4); reset button -> game_reset pulse, count 0.
